// File: rtl/packet_cutter_arbiter.sv
// Packet-granular round-robin arbiter sharing one packet_cutter among 4 AXI-Stream ports.
// Optional statistics outputs (pkt_count, drop_req) are built when CUT_ARB_STATS_EN is defined.
module packet_cutter_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [4*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [4*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [4*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [3:0]                        s_axis_tvalid,
  input  logic [3:0]                        s_axis_tlast,
  output logic [3:0]                        s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic [3:0]                        port_cut_en,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   port_cut_offset,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   port_cut_words,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   port_cut_bytes,
  output logic                              cut_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     cut_offset,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     cut_words,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     cut_bytes,
  output logic [1:0]                        grant,
  output logic                              busy
`ifdef CUT_ARB_STATS_EN
  ,
  output logic [4*32-1:0]                   pkt_count,
  output logic [3:0]                        drop_req
`endif
);

  localparam int N  = 4;
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int CW = C_S_AXI_DATA_WIDTH;

  typedef enum logic {IDLE, PASS} state_t;

  state_t     state;
  logic [1:0] last_grant;
  logic [1:0] req_port;
  logic [1:0] cand;
  logic       req_hit;
  logic       pkt_done;

  // Search starts just after the last winner, so the port that just finished ranks last.
  always_comb begin
    req_hit  = 1'b0;
    req_port = last_grant;
    cand     = last_grant;
    for (int i = 1; i <= N; i++) begin
      cand = last_grant + 2'(i);
      if (!req_hit && s_axis_tvalid[cand]) begin
        req_hit  = 1'b1;
        req_port = cand;
      end
    end
  end

  always_comb begin
    m_axis_tdata  = s_axis_tdata[grant*DW +: DW];
    m_axis_tstrb  = s_axis_tstrb[grant*(DW/8) +: DW/8];
    m_axis_tuser  = s_axis_tuser[grant*UW +: UW];
    m_axis_tlast  = s_axis_tlast[grant];
    m_axis_tvalid = (state == PASS) && s_axis_tvalid[grant];
    s_axis_tready = '0;
    if (state == PASS)
      s_axis_tready[grant] = m_axis_tready;
  end

  assign pkt_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign busy     = (state == PASS);

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      cut_en     <= 1'b0;
      cut_offset <= '0;
      cut_words  <= '0;
      cut_bytes  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hit) begin
            grant      <= req_port;
            last_grant <= req_port;
            cut_en     <= port_cut_en[req_port];
            cut_offset <= port_cut_offset[req_port*CW +: CW];
            cut_words  <= port_cut_words[req_port*CW +: CW];
            cut_bytes  <= port_cut_bytes[req_port*CW +: CW];
            state      <= PASS;
          end
        end
        PASS: begin
          if (pkt_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CUT_ARB_STATS_EN
  // drop_req is registered, so it shows in the first PASS cycle of the grant it lost.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_count <= '0;
      drop_req  <= '0;
    end else begin
      if (pkt_done)
        pkt_count[grant*32 +: 32] <= pkt_count[grant*32 +: 32] + 32'd1;
      if (state == IDLE && req_hit)
        drop_req <= s_axis_tvalid & ~(4'b0001 << req_port);
      else
        drop_req <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_packet_cutter_arbiter.sv
// Randomized self-checking bench for packet_cutter_arbiter against a packet-level model.
module tb_packet_cutter_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int CW = 32;

  logic                 axi_aclk = 1'b0;
  logic                 axi_reset;
  logic [N*DW-1:0]      s_axis_tdata;
  logic [N*DW/8-1:0]    s_axis_tstrb;
  logic [N*UW-1:0]      s_axis_tuser;
  logic [N-1:0]         s_axis_tvalid;
  logic [N-1:0]         s_axis_tlast;
  logic [N-1:0]         s_axis_tready;
  logic [DW-1:0]        m_axis_tdata;
  logic [DW/8-1:0]      m_axis_tstrb;
  logic [UW-1:0]        m_axis_tuser;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;
  logic [N-1:0]         port_cut_en;
  logic [N*CW-1:0]      port_cut_offset;
  logic [N*CW-1:0]      port_cut_words;
  logic [N*CW-1:0]      port_cut_bytes;
  logic                 cut_en;
  logic [CW-1:0]        cut_offset;
  logic [CW-1:0]        cut_words;
  logic [CW-1:0]        cut_bytes;
  logic [1:0]           grant;
  logic                 busy;
`ifdef CUT_ARB_STATS_EN
  logic [N*32-1:0]      pkt_count;
  logic [N-1:0]         drop_req;
`endif

  packet_cutter_arbiter #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_S_AXI_DATA_WIDTH(CW)
  ) dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .port_cut_en(port_cut_en), .port_cut_offset(port_cut_offset),
    .port_cut_words(port_cut_words), .port_cut_bytes(port_cut_bytes),
    .cut_en(cut_en), .cut_offset(cut_offset), .cut_words(cut_words), .cut_bytes(cut_bytes),
    .grant(grant), .busy(busy)
`ifdef CUT_ARB_STATS_EN
    , .pkt_count(pkt_count), .drop_req(drop_req)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  int errors = 0;
  int checks = 0;

  // Packet-level reference: who owns the cutter, who won last, and each port's packet progress.
  int          owner;
  int          last_g;
  int          m_beat [N];
  int          m_len  [N];
  int          m_seq  [N];
  logic [1:0]  exp_grant;
  logic        exp_en;
  logic [CW-1:0] exp_off, exp_words, exp_bytes;
  logic [31:0] exp_cnt [N];
  logic [N-1:0] exp_drop;
  logic [N-1:0] v;
  logic        mready;
  logic [N-1:0] cfg_en;
  logic [CW-1:0] cfg_off [N];
  logic [CW-1:0] cfg_words [N];
  logic [CW-1:0] cfg_bytes [N];

  function automatic logic [31:0] beat_word(int p, int seq, int beat);
    return (32'(p) << 28) | ((32'(seq) & 32'hFFFFF) << 8) | (32'(beat) & 32'hFF);
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    owner     = -1;
    last_g    = 3;
    exp_grant = 2'd0;
    exp_en    = 1'b0;
    exp_off   = '0;
    exp_words = '0;
    exp_bytes = '0;
    exp_drop  = '0;
    for (int p = 0; p < N; p++) exp_cnt[p] = '0;
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < N; p++) begin
      v[p]         = ($urandom_range(0, 3) != 0);
      cfg_en[p]    = 1'($urandom_range(0, 1));
      cfg_off[p]   = $urandom;
      cfg_words[p] = $urandom;
      cfg_bytes[p] = $urandom;
      s_axis_tdata[p*DW +: DW]       = {8{beat_word(p, m_seq[p], m_beat[p])}};
      s_axis_tstrb[p*(DW/8) +: DW/8] = '1;
      s_axis_tuser[p*UW +: UW]       = UW'(m_len[p] * 32);
      s_axis_tlast[p]                = (m_beat[p] == m_len[p] - 1);
      port_cut_en[p]                 = cfg_en[p];
      port_cut_offset[p*CW +: CW]    = cfg_off[p];
      port_cut_words[p*CW +: CW]     = cfg_words[p];
      port_cut_bytes[p*CW +: CW]     = cfg_bytes[p];
    end
    s_axis_tvalid = v;
    mready        = ($urandom_range(0, 3) != 0);
    m_axis_tready = mready;
  endtask

  task automatic checkAll();
    int gp;
    logic [N-1:0] exp_rdy;
    gp      = (owner >= 0) ? owner : int'(exp_grant);
    exp_rdy = (owner >= 0) ? (N'(mready) << owner) : '0;
    checkOutput("m_tvalid", DW'(m_axis_tvalid), DW'((owner >= 0) ? v[owner] : 1'b0));
    checkOutput("s_tready", DW'(s_axis_tready), DW'(exp_rdy));
    checkOutput("m_tdata", m_axis_tdata, {8{beat_word(gp, m_seq[gp], m_beat[gp])}});
    checkOutput("m_tlast", DW'(m_axis_tlast), DW'(m_beat[gp] == m_len[gp] - 1));
    checkOutput("m_tuser", DW'(m_axis_tuser), DW'(m_len[gp] * 32));
    checkOutput("m_tstrb", DW'(m_axis_tstrb), DW'({(DW/8){1'b1}}));
    checkOutput("grant", DW'(grant), DW'(exp_grant));
    checkOutput("busy", DW'(busy), DW'(owner >= 0));
    checkOutput("cut_en", DW'(cut_en), DW'(exp_en));
    checkOutput("cut_offset", DW'(cut_offset), DW'(exp_off));
    checkOutput("cut_words", DW'(cut_words), DW'(exp_words));
    checkOutput("cut_bytes", DW'(cut_bytes), DW'(exp_bytes));
`ifdef CUT_ARB_STATS_EN
    for (int p = 0; p < N; p++)
      checkOutput("pkt_count", DW'(pkt_count[p*32 +: 32]), DW'(exp_cnt[p]));
    checkOutput("drop_req", DW'(drop_req), DW'(exp_drop));
`endif
  endtask

  // Advance the model by one clock edge using the values just driven.
  task automatic modelEdge();
    int p;
    logic found;
    found = 1'b0;
    if (owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        p = (last_g + i) % N;
        if (!found && v[p]) begin
          found     = 1'b1;
          owner     = p;
          last_g    = p;
          exp_grant = 2'(p);
          exp_en    = cfg_en[p];
          exp_off   = cfg_off[p];
          exp_words = cfg_words[p];
          exp_bytes = cfg_bytes[p];
          exp_drop  = v & ~(N'(1) << p);
        end
      end
      if (!found) exp_drop = '0;
    end else begin
      exp_drop = '0;
      if (v[owner] && mready) begin
        if (m_beat[owner] == m_len[owner] - 1) begin
          exp_cnt[owner] = exp_cnt[owner] + 32'd1;
          m_seq[owner]++;
          m_beat[owner] = 0;
          m_len[owner]  = $urandom_range(1, 4);
          owner = -1;
        end else begin
          m_beat[owner]++;
        end
      end
    end
  endtask

  initial begin
    logic did_reset;
    logic release_pending;
    did_reset       = 1'b0;
    release_pending = 1'b0;
    for (int p = 0; p < N; p++) begin
      m_beat[p] = 0;
      m_seq[p]  = 0;
      m_len[p]  = $urandom_range(1, 4);
    end
    axi_reset = 1'b1;
    modelReset();
    applyStimulus();
    #2;
    checkAll();
    @(negedge axi_aclk);
    axi_reset = 1'b0;
    applyStimulus();
    #1;
    checkAll();
    modelEdge();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge axi_aclk);
      if (release_pending) begin
        axi_reset       = 1'b0;
        release_pending = 1'b0;
      end
      applyStimulus();
      #1;
      checkAll();
      if (!did_reset && cyc > 1500 && owner >= 0 && m_beat[owner] > 0 && v[owner]) begin
        did_reset = 1'b1;
        axi_reset = 1'b1;
        #1;
        checkOutput("rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        checkOutput("rst_tready", DW'(s_axis_tready), DW'(0));
        checkOutput("rst_busy", DW'(busy), DW'(1'b0));
        checkOutput("rst_grant", DW'(grant), DW'(0));
        checkOutput("rst_cut_bytes", DW'(cut_bytes), DW'(0));
        m_beat[owner] = 0;
        m_seq[owner]++;
        modelReset();
        release_pending = 1'b1;
      end else begin
        modelEdge();
      end
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
